// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default opcodes and FSM state type.
package alu_pkg;

  localparam logic [7:0] OP_ADD_DEF = 8'h01;
  localparam logic [7:0] OP_SUB_DEF = 8'h02;
  localparam logic [7:0] OP_MUL_DEF = 8'h03;
  localparam logic [7:0] OP_DIV_DEF = 8'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU.
//
// Handshake: the requester holds i_ready high with valid operands and opcode;
// the ALU takes them on a rising edge where it is idle (busy=0). While busy=1
// i_ready is ignored, never queued. Completion is a single-cycle o_ready
// pulse; result_Hi, result_Lo and err are valid with it and hold until the
// next accepted request completes.
interface seq_alu_if #(
  parameter int BITNESS = 8
);
  logic [BITNESS-1:0] i_num_1;
  logic [BITNESS-1:0] i_num_2;
  logic [7:0]         op_code;
  logic               i_ready;
  logic               busy;
  logic [BITNESS-1:0] result_Hi;
  logic [BITNESS-1:0] result_Lo;
  logic               err;
  logic               o_ready;

  modport master (
    output i_num_1, i_num_2, op_code, i_ready,
    input  busy, result_Hi, result_Lo, err, o_ready
  );

  modport slave (
    input  i_num_1, i_num_2, op_code, i_ready,
    output busy, result_Hi, result_Lo, err, o_ready
  );
endinterface

// File: rtl/seq_alu_div.sv
// Restoring unsigned divider, one quotient bit per clock.
// o_done is high during the cycle whose closing edge computes the last bit,
// so quotient/remainder are final right after that edge.
module seq_alu_div #(
  parameter int BITNESS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [BITNESS-1:0] i_dividend,
  input  logic [BITNESS-1:0] i_divisor,
  output logic               o_done,
  output logic [BITNESS-1:0] o_quotient,
  output logic [BITNESS-1:0] o_remainder
);
  localparam int CNT_W = $clog2(BITNESS);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [BITNESS-1:0] r_quo;
  logic [BITNESS-1:0] r_rem;
  logic [BITNESS-1:0] r_div;
  logic [BITNESS:0]   w_shift;
  logic [BITNESS:0]   w_diff;
  logic               w_last;

  assign w_shift = {r_rem, r_quo[BITNESS-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_last  = (r_cnt == CNT_W'(BITNESS - 1));
  assign o_done      = r_busy && w_last;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  // Load operands on start, then shift/trial-subtract/restore each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      if (!w_diff[BITNESS]) begin
        r_rem <= w_diff[BITNESS-1:0];
        r_quo <= {r_quo[BITNESS-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[BITNESS-1:0];
        r_quo <= {r_quo[BITNESS-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: add/sub in one pass, iterative shift-add multiply and
// (optionally) restoring divide. Define SEQ_ALU_DIV_EN to build the divider;
// without it OP_DIV is handled as an unknown opcode.
module seq_alu
  import alu_pkg::*;
#(
  parameter int         BITNESS = 8,
  parameter logic [7:0] OP_ADD  = OP_ADD_DEF,
  parameter logic [7:0] OP_SUB  = OP_SUB_DEF,
  parameter logic [7:0] OP_MUL  = OP_MUL_DEF,
  parameter logic [7:0] OP_DIV  = OP_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus,
  output state_t     o_dbg_state
);
  localparam int CNT_W = $clog2(BITNESS);

  state_t             r_state;
  logic               r_busy;
  logic               r_o_ready;
  logic               r_err_out;
  logic [BITNESS-1:0] r_res_hi;
  logic [BITNESS-1:0] r_res_lo;
  logic [BITNESS-1:0] r_hi;
  logic [BITNESS-1:0] r_lo;
  logic [BITNESS-1:0] r_b;
  logic               r_err;
  logic               r_is_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [BITNESS:0]   w_add;
  logic [BITNESS:0]   w_sub;
  logic [BITNESS:0]   w_mul_sum;
  logic               w_calc_last;
  logic               w_div_done;
  logic [BITNESS-1:0] w_quo;
  logic [BITNESS-1:0] w_rem;

  assign w_add     = {1'b0, bus.i_num_1} + {1'b0, bus.i_num_2};
  assign w_sub     = {1'b0, bus.i_num_1} - {1'b0, bus.i_num_2};
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_calc_last = r_is_div ? w_div_done : (r_cnt == CNT_W'(BITNESS - 1));

`ifdef SEQ_ALU_DIV_EN
  logic w_div_start;
  assign w_div_start = (r_state == IDLE) && bus.i_ready &&
                       (bus.op_code == OP_DIV) && (bus.i_num_2 != '0);

  seq_alu_div #(.BITNESS(BITNESS)) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (bus.i_num_1),
    .i_divisor   (bus.i_num_2),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );
`else
  assign w_div_done = 1'b0;
  assign w_quo      = '0;
  assign w_rem      = '0;
`endif

  assign bus.busy      = r_busy;
  assign bus.o_ready   = r_o_ready;
  assign bus.err       = r_err_out;
  assign bus.result_Hi = r_res_hi;
  assign bus.result_Lo = r_res_lo;
  assign o_dbg_state   = r_state;

  // Control FSM with registered outputs; the multiplier iterates inline in CALC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_o_ready <= 1'b0;
      r_err_out <= 1'b0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_err     <= 1'b0;
      r_is_div  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_o_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_ready) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_b      <= bus.i_num_2;
            r_is_div <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= DONE;
            case (bus.op_code)
              OP_ADD: begin
                r_hi <= {{(BITNESS-1){1'b0}}, w_add[BITNESS]};
                r_lo <= w_add[BITNESS-1:0];
              end
              OP_SUB: begin
                r_hi <= {BITNESS{w_sub[BITNESS]}};
                r_lo <= w_sub[BITNESS-1:0];
              end
              OP_MUL: begin
                r_hi    <= '0;
                r_lo    <= bus.i_num_1;
                r_state <= CALC;
              end
              OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                if (bus.i_num_2 == '0) begin
                  r_hi  <= '1;
                  r_lo  <= bus.i_num_1;
                  r_err <= 1'b1;
                end else begin
                  r_is_div <= 1'b1;
                  r_state  <= CALC;
                end
`else
                r_hi  <= '0;
                r_lo  <= '0;
                r_err <= 1'b1;
`endif
              end
              default: begin
                r_hi  <= '0;
                r_lo  <= '0;
                r_err <= 1'b1;
              end
            endcase
          end
        end
        CALC: begin
          if (!r_is_div) begin
            r_hi <= w_mul_sum[BITNESS:1];
            r_lo <= {w_mul_sum[0], r_lo[BITNESS-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_calc_last) r_state <= DONE;
        end
        DONE: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_o_ready <= 1'b1;
          r_err_out <= r_err;
          r_res_hi  <= r_is_div ? w_quo : r_hi;
          r_res_lo  <= r_is_div ? w_rem : r_lo;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (BITNESS=8), with an expected-result queue.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int B = 8;
  localparam int W = 2 * B + 1;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  seq_alu_if #(.BITNESS(B)) bus ();

  seq_alu #(.BITNESS(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset && bus.o_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_ready", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_val("result", {15'd0, bus.err, bus.result_Hi, bus.result_Lo}, {15'd0, e});
      end
    end
  end

  // ---------------- drivers ----------------
  // Issue one request, check latency, busy, pulse width and result hold.
  task automatic do_op(input logic [7:0] op, input logic [B-1:0] a, input logic [B-1:0] b,
                       input logic [B-1:0] e_hi, input logic [B-1:0] e_lo, input logic e_err,
                       input int e_lat, input bit poke);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.op_code = op;
    bus.i_num_1 = a;
    bus.i_num_2 = b;
    bus.i_ready = 1'b1;
    exp_q.push_back({e_err, e_hi, e_lo});
    @(posedge clk);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      bus.i_ready = poke && (n == 3 || n == 5);
      if (poke) begin
        bus.op_code = OP_ADD_DEF;
        bus.i_num_1 = 8'd1;
        bus.i_num_2 = 8'd1;
      end
      if (n == 1) check_val("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      if (bus.o_ready) seen = 1;
    end
    bus.i_ready = 1'b0;
    if (!seen) check_val("ready_timeout", 32'd0, 32'd1);
    else check_val("latency", n, e_lat);
    @(negedge clk);
    check_val("ready_one_cycle", {31'd0, bus.o_ready}, 32'd0);
    check_val("busy_idle", {31'd0, bus.busy}, 32'd0);
    check_val("hold_hi", {24'd0, bus.result_Hi}, {24'd0, e_hi});
    check_val("hold_lo", {24'd0, bus.result_Lo}, {24'd0, e_lo});
  endtask

  // Hold one add request high; it must complete twice, back to back.
  task automatic do_back_to_back();
    int pulses;
    @(negedge clk);
    bus.op_code = OP_ADD_DEF;
    bus.i_num_1 = 8'd10;
    bus.i_num_2 = 8'd20;
    bus.i_ready = 1'b1;
    exp_q.push_back({1'b0, 8'd0, 8'd30});
    exp_q.push_back({1'b0, 8'd0, 8'd30});
    @(posedge clk);
    pulses = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (bus.o_ready) pulses++;
      if (n == 2) check_val("b2b_first", {31'd0, bus.o_ready}, 32'd1);
      if (n == 4) check_val("b2b_second", {31'd0, bus.o_ready}, 32'd1);
    end
    bus.i_ready = 1'b0;
    check_val("b2b_pulses", pulses, 32'd2);
    repeat (3) @(negedge clk);
  endtask

  // Start a multiply, reset it four cycles in, then check for a clean restart.
  task automatic do_reset_abort();
    int pulses;
    @(negedge clk);
    bus.op_code = OP_MUL_DEF;
    bus.i_num_1 = 8'd255;
    bus.i_num_2 = 8'd255;
    bus.i_ready = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      bus.i_ready = 1'b0;
    end
    check_val("mid_mul_state", {30'd0, dbg_state}, {30'd0, CALC});
    reset = 1'b0;
    #1;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check_val("rst_err", {31'd0, bus.err}, 32'd0);
    check_val("rst_hi", {24'd0, bus.result_Hi}, 32'd0);
    check_val("rst_lo", {24'd0, bus.result_Lo}, 32'd0);
    check_val("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_ready) pulses++;
    end
    check_val("abort_no_ready", pulses, 32'd0);
    do_op(OP_ADD_DEF, 8'd1, 8'd1, 8'd0, 8'd2, 1'b0, 2, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    bus.i_num_1 = '0;
    bus.i_num_2 = '0;
    bus.op_code = '0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("init_busy", {31'd0, bus.busy}, 32'd0);
    check_val("init_ready", {31'd0, bus.o_ready}, 32'd0);
    check_val("init_err", {31'd0, bus.err}, 32'd0);
    check_val("init_hi", {24'd0, bus.result_Hi}, 32'd0);
    check_val("init_lo", {24'd0, bus.result_Lo}, 32'd0);
    check_val("init_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b1;
    repeat (2) @(negedge clk);

    //     op          a       b       hi      lo      err   lat poke
    do_op(OP_ADD_DEF, 8'd200, 8'd100, 8'd1,   8'd44,  1'b0, 2,  1'b0);
    do_op(OP_ADD_DEF, 8'd3,   8'd4,   8'd0,   8'd7,   1'b0, 2,  1'b0);
    do_op(OP_ADD_DEF, 8'd255, 8'd1,   8'd1,   8'd0,   1'b0, 2,  1'b0);
    do_op(OP_SUB_DEF, 8'd5,   8'd7,   8'd255, 8'd254, 1'b0, 2,  1'b0);
    do_op(OP_SUB_DEF, 8'd7,   8'd5,   8'd0,   8'd2,   1'b0, 2,  1'b0);
    do_op(OP_SUB_DEF, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 2,  1'b0);
    do_op(OP_MUL_DEF, 8'd255, 8'd255, 8'd254, 8'd1,   1'b0, 10, 1'b1);
    do_op(OP_MUL_DEF, 8'd13,  8'd11,  8'd0,   8'd143, 1'b0, 10, 1'b0);
    do_op(OP_MUL_DEF, 8'd16,  8'd16,  8'd1,   8'd0,   1'b0, 10, 1'b0);
    do_op(OP_MUL_DEF, 8'd0,   8'd200, 8'd0,   8'd0,   1'b0, 10, 1'b0);
    do_op(8'h07,      8'd12,  8'd34,  8'd0,   8'd0,   1'b1, 2,  1'b0);
    do_op(OP_ADD_DEF, 8'd9,   8'd9,   8'd0,   8'd18,  1'b0, 2,  1'b0);
    do_op(8'h00,      8'd1,   8'd2,   8'd0,   8'd0,   1'b1, 2,  1'b0);
`ifdef SEQ_ALU_DIV_EN
    do_op(OP_DIV_DEF, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 10, 1'b0);
    do_op(OP_DIV_DEF, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 10, 1'b0);
    do_op(OP_DIV_DEF, 8'd9,   8'd0,   8'd255, 8'd9,   1'b1, 2,  1'b0);
`else
    do_op(OP_DIV_DEF, 8'd200, 8'd7,   8'd0,   8'd0,   1'b1, 2,  1'b0);
    do_op(OP_DIV_DEF, 8'd9,   8'd0,   8'd0,   8'd0,   1'b1, 2,  1'b0);
`endif
    do_back_to_back();
    do_reset_abort();

    repeat (2) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
